unary_bitstream_decoder: RTL
============================

// Module: unary_bitstream_decoder
// PURPOSE
//  Unary-to-binary decoder: counts 1s in a unary bitstream over one window of 2**BITWIDTH
//  enabled samples and returns the binary value.
//  Receive end of the sobolrng + comparator encoder path; one instance per decoded stream.
//  Result leaves on a valid/ready handshake; back-to-back windows via iStart chaining.
// PARAMETERS
//  BITWIDTH  8  result width; window length WIN = 2**BITWIDTH enabled samples
// PORTS
//  iClk      in   1         clock, all state on rising edge
//  iRst      in   1         reset, asynchronous, active-high
//  iStart    in   1         begin a window (IDLE, or chain on last sample)
//  iEn       in   1         iBit is a valid sample this cycle
//  iBit      in   1         unary stream bit
//  iClr      in   1         synchronous abort: drop window and pending result
//  oBin      out  BITWIDTH  decoded 1s count, saturated
//  oValid    out  1         oBin holds an unconsumed result
//  iReady    in   1         consumer accepts oBin when oValid && iReady
//  oBusy     out  1         window in progress (state RUN)
//  oOverrun  out  1         one-cycle pulse: window completed while previous result pending
// BEHAVIOUR
//  Reset: state IDLE; sample cnt, ones cnt, oBin, oValid, oOverrun = 0; oBusy = 0.
//  Registers: smpCnt [BITWIDTH-1:0], onesCnt [BITWIDTH:0] (one extra bit).
//  FSM IDLE: iEn/iBit ignored; iStart -> RUN with smpCnt=0, onesCnt=0 next cycle.
//  FSM RUN: per cycle with iEn: smpCnt += 1, onesCnt += iBit. No iEn: hold.
//   Last sample = iEn && smpCnt == WIN-1. On that edge:
//   - result R = onesCnt + iBit (includes final bit); R == WIN saturates to WIN-1.
//   - if !oValid, or oValid && iReady same cycle: oBin <= R, oValid <= 1 next cycle.
//   - else (pending unaccepted): R discarded, oBin unchanged, oOverrun = 1 next cycle.
//   - iStart high on this cycle: stay RUN, counters cleared (0-bubble chaining);
//     else -> IDLE.
//  Latency: oValid rises the cycle after the last sample's edge (1 cycle).
//  Handshake: oValid && iReady on edge -> oValid <= 0 unless new result loads that edge.
//   oBin stable while oValid && !iReady. iReady ignored when !oValid.
//  iStart in RUN other than on last sample cycle: ignored.
//  iClr (priority over everything except iRst): next cycle state IDLE, counters 0,
//   oValid 0, oOverrun 0; oBin retains old value (don't-care when oValid=0).
//  iRst asserted mid-window: immediate return to reset values, partial count lost.
//  oOverrun: never sticky; high exactly one cycle per dropped result.
//  Wrap: smpCnt wraps WIN-1 -> 0 only via last-sample rule; onesCnt never wraps (<= WIN).
//  oBusy = (state == RUN), combinational from state register.
// TESTING
//  BITWIDTH=3, iStart pulse, 8 samples iBit=1,0,1,1,0,0,1,0 iEn=1 -> oValid one cycle
//   after 8th sample, oBin=4, oBusy falls same cycle.
//  BITWIDTH=3, all 8 samples iBit=1 -> oBin=7 (saturated); all 0 -> oBin=0.
//  BITWIDTH=3, iEn gaps (1 of every 3 cycles) with 3 ones -> oBin=3 after 24 cycles.
//  BITWIDTH=8, sobolrng + compare (rand < 100) driving iBit, iStart held high ->
//   every window oBin=100, no gap between windows, no overrun with iReady=1.
//  Chained windows, iReady=0: 2nd completion -> oOverrun 1-cycle pulse, oBin=first result;
//   iReady=1 on 2nd completion cycle -> no overrun, oBin=second result, oValid stays 1.
//  iClr at sample 5 of 8, or iRst mid-window -> IDLE, oValid=0, next iStart window exact.

Source files
------------

// File: rtl/unary_bitstream_decoder.sv
// unary_bitstream_decoder: counts the 1s in one window of 2**BITWIDTH enabled
// samples of a unary bitstream and returns the saturated count as a binary value.
//
// Ports:
//   iClk      clock, all state on rising edge
//   iRst      asynchronous active-high reset
//   iStart    begin a window from IDLE, or chain a new window on the last sample
//   iEn       iBit is a valid sample this cycle
//   iBit      unary stream bit
//   iClr      synchronous abort: drops the window in progress and any pending result
//   oBin      decoded 1s count, saturated to 2**BITWIDTH-1
//   oValid    oBin holds an unconsumed result
//   iReady    consumer accepts oBin when oValid && iReady
//   oBusy     a window is in progress
//   oOverrun  one-cycle pulse: a window completed while the previous result was pending
module unary_bitstream_decoder #(
    parameter int BITWIDTH = 8
) (
    input  logic                iClk,
    input  logic                iRst,
    input  logic                iStart,
    input  logic                iEn,
    input  logic                iBit,
    input  logic                iClr,
    output logic [BITWIDTH-1:0] oBin,
    output logic                oValid,
    input  logic                iReady,
    output logic                oBusy,
    output logic                oOverrun
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t state, nextState;
    logic [BITWIDTH-1:0] smpCnt;
    logic [BITWIDTH:0]   onesCnt;
    logic [BITWIDTH:0]   sum;
    logic [BITWIDTH-1:0] result;
    logic                lastSmp;
    logic                canLoad;
    always_comb begin
        lastSmp   = state == RUN && iEn && smpCnt == {BITWIDTH{1'b1}};
        sum       = onesCnt + {{BITWIDTH{1'b0}}, iBit};
        // a window of all 1s counts WIN, which does not fit; clamp to WIN-1
        result    = sum[BITWIDTH] ? {BITWIDTH{1'b1}} : sum[BITWIDTH-1:0];
        // the slot is free if empty or being emptied on this same edge
        canLoad   = !oValid || iReady;
        nextState = iClr ? IDLE :
                    state == IDLE ? (iStart ? RUN : IDLE) :
                    (lastSmp && !iStart) ? IDLE : RUN;
        oBusy     = state == RUN;
    end
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) state <= IDLE;
        else      state <= nextState;
    end
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            smpCnt   <= '0;
            onesCnt  <= '0;
            oBin     <= '0;
            oValid   <= 1'b0;
            oOverrun <= 1'b0;
        end else if (iClr) begin
            smpCnt   <= '0;
            onesCnt  <= '0;
            oValid   <= 1'b0;
            oOverrun <= 1'b0;
        end else begin
            // counters sit at zero in IDLE and restart on the last sample, which
            // gives bubble-free chaining when iStart is held there
            if (state == IDLE || lastSmp) begin
                smpCnt  <= '0;
                onesCnt <= '0;
            end else if (iEn) begin
                smpCnt  <= smpCnt + 1'b1;
                onesCnt <= sum;
            end
            oOverrun <= lastSmp && !canLoad;
            if (lastSmp && canLoad) begin
                oBin   <= result;
                oValid <= 1'b1;
            end else if (iReady) begin
                oValid <= 1'b0;
            end
        end
    end
endmodule
